// File: rtl/exibe_pkg.sv
// Shared encodings and sizing helpers for the sequence presenter.
// Pure declarations: no logic, no latency, no flow control.
package exibe_pkg;

    localparam int ESTADO_W      = 4;
    localparam int DATA_W_PADRAO = 4;
    localparam int ADDR_W_PADRAO = 4;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO          = 4'd0,
        CARREGA         = 4'd1,
        ACENDE          = 4'd2,
        APAGA           = 4'd3,
        PROXIMO         = 4'd4,
        FIM             = 4'd5,
        ESTADO_INVALIDO = 4'd8
    } estado_t;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int valor);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < valor) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int largura_contador(input int valor);
        return (clog2(valor) < 1) ? 1 : clog2(valor);
    endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// Modulo-M cycle counter; fim is high while the count sits at M-1.
// Latency: count updates on the clock after conta; fim is combinational from the count.
// Backpressure: conta=0 freezes the count, zera clears it (zera has priority).
module temporizador_m
    import exibe_pkg::*;
#(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = largura_contador(M);
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta) begin
            // Wrap on the last count so a back-to-back use starts clean.
            if (contagem == ULTIMO) begin
                contagem <= '0;
            end else begin
                contagem <= contagem + W'(1);
            end
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/exibe_sequencia.sv
// Memory-game sequence presenter: walks ROM 0..limite, lighting each word T_ON clocks then T_OFF dark.
// Latency: item k spans cycles 1+P*k..P*(k+1) after iniciar, P = 2+T_ON+T_OFF; pronto at 1+P*(limite+1).
// Backpressure: iniciar ignored while ocupado; with PAUSA_EN defined, pausa freezes ACENDE/APAGA timing.
module exibe_sequencia
    import exibe_pkg::*;
#(
    parameter int DATA_W = DATA_W_PADRAO,
    parameter int ADDR_W = ADDR_W_PADRAO,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [ADDR_W-1:0]   limite,
    input  logic [DATA_W-1:0]   dado,
`ifdef PAUSA_EN
    input  logic                pausa,
`endif
    output logic [ADDR_W-1:0]   endereco,
    output logic [DATA_W-1:0]   leds,
    output logic                ocupado,
    output logic                pronto,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t           estado;
    estado_t           proximo_estado;
    logic [ADDR_W-1:0] endereco_reg;
    logic [ADDR_W-1:0] limite_reg;
    logic              avanca;
    logic              fim_on;
    logic              fim_off;
    logic              ultimo_item;

`ifdef PAUSA_EN
    assign avanca = ~pausa;
`else
    assign avanca = 1'b1;
`endif

    // Compare happens before any increment, so the address never wraps past the last word.
    assign ultimo_item = (endereco_reg == limite_reg);

    temporizador_m #(.M(T_ON)) u_tempo_aceso (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ACENDE),
        .conta (avanca),
        .fim   (fim_on)
    );

    temporizador_m #(.M(T_OFF)) u_tempo_apagado (
        .clock (clock),
        .reset (reset),
        .zera  (estado != APAGA),
        .conta (avanca),
        .fim   (fim_off)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo_estado;
        end
    end

    always_comb begin
        proximo_estado = OCIOSO;
        case (estado)
            OCIOSO:  proximo_estado = iniciar ? CARREGA : OCIOSO;
            CARREGA: proximo_estado = ACENDE;
            ACENDE:  proximo_estado = (fim_on && avanca) ? APAGA : ACENDE;
            APAGA:   proximo_estado = (fim_off && avanca) ? PROXIMO : APAGA;
            PROXIMO: proximo_estado = ultimo_item ? FIM : CARREGA;
            FIM:     proximo_estado = OCIOSO;
            default: proximo_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco_reg <= '0;
            limite_reg   <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    endereco_reg <= '0;
                    if (iniciar) begin
                        limite_reg <= limite;
                    end
                end
                PROXIMO: begin
                    if (!ultimo_item) begin
                        endereco_reg <= endereco_reg + ADDR_W'(1);
                    end
                end
                FIM:     endereco_reg <= '0;
                default: endereco_reg <= endereco_reg;
            endcase
        end
    end

    always_comb begin
        leds      = '0;
        ocupado   = 1'b1;
        pronto    = 1'b0;
        db_estado = ESTADO_INVALIDO;
        case (estado)
            OCIOSO: begin
                ocupado   = 1'b0;
                db_estado = OCIOSO;
            end
            CARREGA: db_estado = CARREGA;
            ACENDE: begin
                leds      = dado;
                db_estado = ACENDE;
            end
            APAGA:   db_estado = APAGA;
            PROXIMO: db_estado = PROXIMO;
            FIM: begin
                pronto    = 1'b1;
                db_estado = FIM;
            end
            default: begin
                ocupado   = 1'b0;
                db_estado = ESTADO_INVALIDO;
            end
        endcase
    end

    assign endereco = endereco_reg;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ON=4, T_OFF=2 and a sync 16x4 ROM model.
// Stimulus pushes expected events into a queue; a negedge monitor pops and compares them.
module tb_exibe_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int P     = 2 + T_ON + T_OFF;

    localparam int EV_INICIO   = 0;
    localparam int EV_ACESO    = 1;
    localparam int EV_APAGADO  = 2;
    localparam int EV_PRONTO   = 3;
    localparam int EV_FIM      = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] limite  = 4'd0;
    logic [3:0] dado    = 4'd0;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;
`ifdef PAUSA_EN
    logic       pausa = 1'b0;
`endif

    logic [3:0] rom [16];

    typedef struct {
        int kind;
        int dat;
        int addr;
        int cyc;
    } ev_t;

    ev_t  sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc_cnt = 0;
    bit   mon_en  = 1'b0;
    logic [3:0] prev_leds = 4'd0;
    logic       prev_ocup = 1'b0;

    exibe_sequencia #(
        .DATA_W (4),
        .ADDR_W (4),
        .T_ON   (T_ON),
        .T_OFF  (T_OFF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .dado      (dado),
`ifdef PAUSA_EN
        .pausa     (pausa),
`endif
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        rom = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};
    end

    always @(posedge clock) begin
        dado    <= rom[endereco];
        cyc_cnt <= cyc_cnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int k, input int d, input int a, input int c);
        ev_t e;
        e.kind = k;
        e.dat  = d;
        e.addr = a;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Expected timeline for one run whose accepting edge ends cycle b (cycle c <-> cyc_cnt b+c).
    task automatic push_run(input int b, input int lim);
        push_ev(EV_INICIO, 1, 0, b + 1);
        for (int k = 0; k <= lim; k++) begin
            push_ev(EV_ACESO, int'(rom[k]), k, b + 2 + P * k);
            push_ev(EV_APAGADO, 3, k, b + 2 + P * k + T_ON);
        end
        push_ev(EV_PRONTO, 5, lim, b + 1 + P * (lim + 1));
        push_ev(EV_FIM, 0, 0, b + 2 + P * (lim + 1));
    endtask

    task automatic check_ev(input int kind, input int dat, input int addr);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected event: got kind=%0d dat=%0d addr=%0d cyc=%0d, required no event",
                     kind, dat, addr, cyc_cnt);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.dat != dat || e.addr != addr || e.cyc != cyc_cnt) begin
                errors++;
                $display("FAIL event: got kind=%0d dat=%0d addr=%0d cyc=%0d, required kind=%0d dat=%0d addr=%0d cyc=%0d",
                         kind, dat, addr, cyc_cnt, e.kind, e.dat, e.addr, e.cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (ocupado && !prev_ocup)       check_ev(EV_INICIO, int'(db_estado), int'(endereco));
            if (leds != 0 && prev_leds == 0) check_ev(EV_ACESO, int'(leds), int'(endereco));
            if (leds == 0 && prev_leds != 0) check_ev(EV_APAGADO, int'(db_estado), int'(endereco));
            if (pronto)                      check_ev(EV_PRONTO, int'(db_estado), int'(endereco));
            if (!ocupado && prev_ocup)       check_ev(EV_FIM, int'(db_estado), int'(endereco));
        end
        prev_leds = leds;
        prev_ocup = ocupado;
    end

    task automatic start_run(input logic [3:0] lim, input bit keep, output int b);
        @(negedge clock);
        iniciar = 1'b1;
        limite  = lim;
        @(posedge clock);
        #1;
        b = cyc_cnt - 1;
        if (!keep) iniciar = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc_cnt < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk(nm, sb.size(), 0);
        repeat (4) @(negedge clock);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_leds"}, int'(leds), 0);
        chk({nm, "_ocupado"}, int'(ocupado), 0);
        chk({nm, "_pronto"}, int'(pronto), 0);
        chk({nm, "_endereco"}, int'(endereco), 0);
        chk({nm, "_db_estado"}, int'(db_estado), 0);
    endtask

    initial begin
        #2;
        chk_idle("reset_inicial");
        #20;
        reset = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;
    end

    initial begin
        int b;
        int b2;
        wait (mon_en == 1'b1);

        // Single item.
        start_run(4'd0, 1'b0, b);
        push_run(b, 0);
        wait_drain("lim0_drain", 60);

        // Four items.
        start_run(4'd3, 1'b0, b);
        push_run(b, 3);
        wait_drain("lim3_drain", 80);

        // Whole ROM, no address wrap.
        start_run(4'd15, 1'b0, b);
        push_run(b, 15);
        wait_drain("lim15_drain", 300);

        // Restart request with a new limite while busy must be ignored.
        start_run(4'd3, 1'b0, b);
        push_run(b, 3);
        wait_cyc(b + 12);
        @(negedge clock);
        iniciar = 1'b1;
        limite  = 4'd0;
        @(negedge clock);
        iniciar = 1'b0;
        wait_drain("repulso_drain", 80);

        // Reset while lit, then a fresh two-item run.
        start_run(4'd3, 1'b0, b);
        push_ev(EV_INICIO, 1, 0, b + 1);
        push_ev(EV_ACESO, int'(rom[0]), 0, b + 2);
        wait_cyc(b + 3);
        #1;
        mon_en = 1'b0;
        chk("pre_reset_leds", int'(leds), int'(rom[0]));
        reset = 1'b1;
        #1;
        chk_idle("reset_meio");
        chk("reset_meio_fila", sb.size(), 0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        mon_en = 1'b1;
        start_run(4'd1, 1'b0, b2);
        push_run(b2, 1);
        wait_drain("pos_reset_drain", 60);

        // iniciar held high through FIM: second run starts right after OCIOSO.
        start_run(4'd0, 1'b1, b);
        push_run(b, 0);
        push_run(b + 10, 0);
        wait_cyc(b + 11);
        iniciar = 1'b0;
        wait_drain("iniciar_preso_drain", 60);

`ifdef PAUSA_EN
        // Three paused cycles inside ACENDE stretch the lit time and delay pronto by 3.
        start_run(4'd0, 1'b0, b);
        push_ev(EV_INICIO, 1, 0, b + 1);
        push_ev(EV_ACESO, int'(rom[0]), 0, b + 2);
        push_ev(EV_APAGADO, 3, 0, b + 9);
        push_ev(EV_PRONTO, 5, 0, b + 12);
        push_ev(EV_FIM, 0, 0, b + 13);
        wait_cyc(b + 3);
        pausa = 1'b1;
        wait_cyc(b + 6);
        pausa = 1'b0;
        wait_drain("pausa_drain", 60);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1);
    end

endmodule
